// File: rtl/segasys1_sprcoll_ctrl_pkg.sv
// segasys1_sprcoll_ctrl_pkg: shared constants, state encoding and CPU data formatting for the sprite-collision controller
// Contents: COLL_AW (flag RAM address width), COLL_CPU_DOUT_PAD (constant upper bits of CPU read data),
// state_t (controller states), coll_dout() (formats a flag bit as a CPU data byte).
package segasys1_sprcoll_ctrl_pkg;
    localparam int COLL_AW = 10;
    localparam logic [6:0] COLL_CPU_DOUT_PAD = 7'h7F;
    typedef enum logic [2:0] {CLR, IDLE, CPU_RD, CPU_RD2, CPU_WR, EVT_WR} state_t;
    function automatic logic [7:0] coll_dout(input logic flag);
        return {COLL_CPU_DOUT_PAD, flag};
    endfunction
endpackage

// File: rtl/segasys1_sprcoll_ctrl_if.sv
// segasys1_sprcoll_ctrl_if: sprite-event and CPU access bundle of the sprite-collision controller
// master: drives sprcoll/sprcoll_ad (sprite engine) and cpu_req/cpu_wr/cpu_sum/cpu_ad (CPU glue),
//         receives cpu_ack/cpu_dout/busy/drop.
// slave:  the controller side of the same signals.
// With SEGASYS1_SPRCOLL_STAT_EN defined, drop_cnt[7:0] and fifo_hwm[FIFO_AW:0] are added as slave outputs.
interface segasys1_sprcoll_ctrl_if #(
    parameter int RAM_AW = 10
`ifdef SEGASYS1_SPRCOLL_STAT_EN
    , parameter int FIFO_AW = 3
`endif
);
    logic              sprcoll;
    logic [RAM_AW-1:0] sprcoll_ad;
    logic              cpu_req;
    logic              cpu_wr;
    logic              cpu_sum;
    logic [RAM_AW-1:0] cpu_ad;
    logic              cpu_ack;
    logic [7:0]        cpu_dout;
    logic              busy;
    logic              drop;
`ifdef SEGASYS1_SPRCOLL_STAT_EN
    logic [7:0]        drop_cnt;
    logic [FIFO_AW:0]  fifo_hwm;
`endif
    modport master (
        output sprcoll, sprcoll_ad, cpu_req, cpu_wr, cpu_sum, cpu_ad,
        input  cpu_ack, cpu_dout, busy, drop
`ifdef SEGASYS1_SPRCOLL_STAT_EN
        , input drop_cnt, fifo_hwm
`endif
    );
    modport slave (
        input  sprcoll, sprcoll_ad, cpu_req, cpu_wr, cpu_sum, cpu_ad,
        output cpu_ack, cpu_dout, busy, drop
`ifdef SEGASYS1_SPRCOLL_STAT_EN
        , output drop_cnt, fifo_hwm
`endif
    );
endinterface

// File: rtl/segasys1_sprcoll_ctrl_fifo.sv
// segasys1_sprcoll_ctrl_fifo: synchronous FIFO buffering sprite collision event addresses
// Ports: clk_i, rst_i (sync, active-high flush), push_i/din_i (write), pop_i (read, dout_o shows head),
//        full_o, level_o (occupancy 0..2**AW; zero means empty).
// A push while full is accepted only when a pop happens in the same cycle.
module segasys1_sprcoll_ctrl_fifo #(
    parameter int W  = 10,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wp_q;
    logic [AW:0]  rp_q;
    logic         wr_en;
    logic         rd_en;
    assign level_o = wp_q - rp_q;
    assign full_o  = level_o[AW];
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rd_en   = pop_i & (level_o != '0);
    assign dout_o  = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wp_q[AW-1:0]] <= din_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wr_en) wp_q <= wp_q + (AW+1)'(1);
            if (rd_en) rp_q <= rp_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/segasys1_sprcoll_ctrl.sv
// segasys1_sprcoll_ctrl: sprite-collision flag RAM owner arbitrating sprite events and CPU read/clear accesses
// Ports: VCLKx4 (clock), RESET (sync, active-high), bus (segasys1_sprcoll_ctrl_if.slave):
//   sprcoll/sprcoll_ad event strobe+address, cpu_req/cpu_wr/cpu_sum/cpu_ad CPU request,
//   cpu_ack/cpu_dout completion and data, busy (clear sweep running), drop (event lost, FIFO full).
// Optional feature macro SEGASYS1_SPRCOLL_STAT_EN: adds drop_cnt (saturating lost-event count,
//   cleared by RESET and CPU summary clear) and fifo_hwm (FIFO high-water mark).
module segasys1_sprcoll_ctrl
    import segasys1_sprcoll_ctrl_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int RAM_AW  = COLL_AW
) (
    input logic                   VCLKx4,
    input logic                   RESET,
    segasys1_sprcoll_ctrl_if.slave bus
);
    state_t            state_q, state_d;
    logic [RAM_AW-1:0] ptr_q, ptr_d;
    logic [RAM_AW-1:0] evt_ad_q, evt_ad_d;
    logic              ack_q, ack_d;
    logic [7:0]        dout_q, dout_d;
    logic              sum_q, sum_d;
    logic              fair_q, fair_d;
    logic              flag_mem [2**RAM_AW];
    logic              rd_q;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_wa;
    logic              ram_wd;
    logic              cpu_go;
    logic              pop;
    logic              drop_w;
    logic [RAM_AW-1:0] f_dout;
    logic              f_full;
    logic [FIFO_AW:0]  f_level;
    logic              f_empty;
    segasys1_sprcoll_ctrl_fifo #(.W(RAM_AW), .AW(FIFO_AW)) u_fifo (
        .clk_i   (VCLKx4),
        .rst_i   (RESET),
        .push_i  (bus.sprcoll),
        .pop_i   (pop),
        .din_i   (bus.sprcoll_ad),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .level_o (f_level)
    );
    assign f_empty = f_level == '0;
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        evt_ad_d = evt_ad_q;
        ack_d    = 1'b0;
        dout_d   = dout_q;
        sum_d    = sum_q;
        fair_d   = fair_q;
        pop      = 1'b0;
        ram_we   = 1'b0;
        ram_wa   = bus.cpu_ad;
        ram_wd   = 1'b0;
        // The ack cycle still sees the finished request, and a CPU op owes the queue one turn.
        cpu_go   = bus.cpu_req & ~ack_q & ~(fair_q & ~f_empty);
        case (state_q)
            CLR: begin
                ram_we = 1'b1;
                ram_wa = ptr_q;
                ptr_d  = ptr_q + RAM_AW'(1);
                if (&ptr_q) state_d = IDLE;
            end
            IDLE: begin
                if (cpu_go) begin
                    state_d = bus.cpu_wr ? CPU_WR : CPU_RD;
                    fair_d  = 1'b1;
                end else if (~f_empty) begin
                    pop      = 1'b1;
                    evt_ad_d = f_dout;
                    fair_d   = 1'b0;
                    state_d  = EVT_WR;
                end
            end
            CPU_RD:  state_d = CPU_RD2;
            CPU_RD2: begin
                dout_d  = coll_dout(bus.cpu_sum ? sum_q : rd_q);
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            CPU_WR: begin
                ram_we  = ~bus.cpu_sum;
                sum_d   = bus.cpu_sum ? 1'b0 : sum_q;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            EVT_WR: begin
                ram_we  = 1'b1;
                ram_wa  = evt_ad_q;
                ram_wd  = 1'b1;
                sum_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = CLR;
        endcase
    end
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state_q  <= CLR;
            ptr_q    <= '0;
            evt_ad_q <= '0;
            ack_q    <= 1'b0;
            dout_q   <= coll_dout(1'b0);
            sum_q    <= 1'b0;
            fair_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            evt_ad_q <= evt_ad_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            sum_q    <= sum_d;
            fair_q   <= fair_d;
        end
    end
    always_ff @(posedge VCLKx4) begin
        if (ram_we) flag_mem[ram_wa] <= ram_wd;
        if (state_q == CPU_RD) rd_q <= flag_mem[bus.cpu_ad];
    end
    assign drop_w       = bus.sprcoll & f_full & ~pop;
    assign bus.drop     = drop_w;
    assign bus.cpu_ack  = ack_q;
    assign bus.cpu_dout = dout_q;
    assign bus.busy     = state_q == CLR;
`ifdef SEGASYS1_SPRCOLL_STAT_EN
    logic [7:0]       drop_cnt_q;
    logic [FIFO_AW:0] hwm_q;
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            drop_cnt_q <= '0;
            hwm_q      <= '0;
        end else begin
            drop_cnt_q <= (state_q == CPU_WR && bus.cpu_sum) ? 8'd0 : drop_cnt_q + 8'(drop_w & ~&drop_cnt_q);
            hwm_q      <= f_level > hwm_q ? f_level : hwm_q;
        end
    end
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.fifo_hwm = hwm_q;
`endif
endmodule

// File: tb/tb_segasys1_sprcoll_ctrl.sv
// tb_segasys1_sprcoll_ctrl: directed, table-driven self-checking bench for segasys1_sprcoll_ctrl
module tb_segasys1_sprcoll_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    segasys1_sprcoll_ctrl_if bus();
    segasys1_sprcoll_ctrl dut (.VCLKx4(clk), .RESET(rst), .bus(bus));
    int n_run  = 0;
    int n_fail = 0;
    typedef struct {
        logic       evt;
        logic [9:0] evt_ad;
        int         gap;
        logic       wr;
        logic       sum;
        logic [9:0] ad;
        logic [7:0] exp;
    } vec_t;
    vec_t tv [14];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Raise a request at the next negedge; lat counts posedges until ack is seen.
    task automatic cpu_op(input logic wr, input logic sum, input logic [9:0] ad, output logic [7:0] dout, output int lat);
        @(negedge clk);
        bus.cpu_wr  = wr;
        bus.cpu_sum = sum;
        bus.cpu_ad  = ad;
        bus.cpu_req = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.cpu_ack && lat < 64);
        if (!bus.cpu_ack) check("cpu_ack_timeout", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 1'b0;
        dout = bus.cpu_dout;
    endtask
    task automatic rd_chk(input string name, input logic sum, input logic [9:0] ad, input logic [7:0] exp);
        logic [7:0] d;
        int l;
        @(posedge clk);
        cpu_op(1'b0, sum, ad, d, l);
        check(name, 32'(d), 32'(exp));
    endtask
    task automatic wr_op(input logic sum, input logic [9:0] ad);
        logic [7:0] d;
        int l;
        @(posedge clk);
        cpu_op(1'b1, sum, ad, d, l);
        check("wr_lat", l, 2);
    endtask
    task automatic pulse(input logic [9:0] ad);
        @(negedge clk);
        bus.sprcoll    = 1'b1;
        bus.sprcoll_ad = ad;
        @(posedge clk);
        #1;
        bus.sprcoll = 1'b0;
    endtask
    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus.cpu_ack), 0);
        check("rst_dout", 32'(bus.cpu_dout), 32'h0FE);
        check("rst_busy", 32'(bus.busy), 1);
        check("rst_drop", 32'(bus.drop), 0);
    endtask
    // Release reset at a negedge and count cycles with busy high, stopping after 'limit'.
    task automatic reset_sweep(input int limit, output int n);
        enter_reset();
        rst = 1'b0;
        n = 0;
        while (bus.busy && n < limit) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        logic [7:0] d;
        int lat;
        int n;
        bus.sprcoll = 1'b0; bus.sprcoll_ad = '0;
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_sum = 1'b0; bus.cpu_ad = '0;
        tv[0]  = '{1'b1, 10'h125, 4, 1'b0, 1'b0, 10'h125, 8'hFF};
        tv[1]  = '{1'b0, 10'h000, 1, 1'b0, 1'b1, 10'h000, 8'hFF};
        tv[2]  = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h124, 8'hFE};
        tv[3]  = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h126, 8'hFE};
        tv[4]  = '{1'b1, 10'h3FF, 4, 1'b0, 1'b0, 10'h3FF, 8'hFF};
        tv[5]  = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h000, 8'hFE};
        tv[6]  = '{1'b0, 10'h000, 1, 1'b1, 1'b0, 10'h125, 8'h00};
        tv[7]  = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h125, 8'hFE};
        tv[8]  = '{1'b0, 10'h000, 1, 1'b0, 1'b1, 10'h000, 8'hFF};
        tv[9]  = '{1'b0, 10'h000, 1, 1'b1, 1'b1, 10'h000, 8'h00};
        tv[10] = '{1'b0, 10'h000, 1, 1'b0, 1'b1, 10'h000, 8'hFE};
        tv[11] = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h3FF, 8'hFF};
        tv[12] = '{1'b1, 10'h000, 4, 1'b0, 1'b1, 10'h000, 8'hFF};
        tv[13] = '{1'b0, 10'h000, 1, 1'b0, 1'b0, 10'h000, 8'hFF};
        // Reset sweep length and a fully cleared RAM.
        reset_sweep(2000, n);
        check("t1_busy_cycles", n, 1024);
        for (int a = 0; a < 1024; a++) rd_chk($sformatf("t1_rd_%0h", a), 1'b0, 10'(a), 8'hFE);
        // Table: events, reads, clears and summary.
        for (int i = 0; i < 14; i++) begin
            if (tv[i].evt) pulse(tv[i].evt_ad);
            repeat (tv[i].gap) @(posedge clk);
            cpu_op(tv[i].wr, tv[i].sum, tv[i].ad, d, lat);
            check($sformatf("vec%0d_lat", i), lat, tv[i].wr ? 2 : 3);
            if (!tv[i].wr) check($sformatf("vec%0d_dout", i), 32'(d), 32'(tv[i].exp));
        end
        // Read pending with an event queued: read first, then event before the next CPU op.
        pulse(10'h010);
        repeat (4) @(posedge clk);
        pulse(10'h055);
        cpu_op(1'b0, 1'b0, 10'h055, d, lat);
        check("t3_rd_lat", lat, 3);
        check("t3_rd_dout", 32'(d), 32'h0FE);
        cpu_op(1'b0, 1'b0, 10'h055, d, lat);
        check("t3_rd2_lat", lat, 5);
        check("t3_rd2_dout", 32'(d), 32'h0FF);
        // Clear of an address whose event is already queued: event lands after the clear.
        pulse(10'h020);
        repeat (4) @(posedge clk);
        pulse(10'h125);
        cpu_op(1'b1, 1'b0, 10'h125, d, lat);
        check("t5_clr_lat", lat, 2);
        @(posedge clk);
        cpu_op(1'b0, 1'b0, 10'h125, d, lat);
        check("t5_rd_lat", lat, 4);
        check("t5_rd_dout", 32'(d), 32'h0FF);
        wr_op(1'b1, 10'h000);
        rd_chk("t5_sum_cleared", 1'b1, 10'h000, 8'hFE);
        // Reset while a read is in flight: no ack, sweep restarts.
        @(negedge clk);
        bus.cpu_wr = 1'b0; bus.cpu_sum = 1'b0; bus.cpu_ad = 10'h3FF; bus.cpu_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6_no_ack_%0d", k), 32'(bus.cpu_ack), 0);
        end
        reset_sweep(500, n);
        check("t6_midsweep_busy", 32'(bus.busy), 1);
        reset_sweep(2000, n);
        check("t6_busy_cycles", n, 1024);
        rd_chk("t6_rd_3ff", 1'b0, 10'h3FF, 8'hFE);
        rd_chk("t6_rd_055", 1'b0, 10'h055, 8'hFE);
        rd_chk("t6_sum", 1'b1, 10'h000, 8'hFE);
        // Overflow during the sweep: 9th event dropped; a push at the first pop edge is kept.
        enter_reset();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.sprcoll = 1'b1;
            bus.sprcoll_ad = 10'h200 + 10'(i);
            #1;
            check($sformatf("t4_drop_%0d", i), 32'(bus.drop), i == 8 ? 1 : 0);
            @(negedge clk);
        end
        bus.sprcoll = 1'b0;
        repeat (1015) @(negedge clk);
        check("t4_busy_done", 32'(bus.busy), 0);
        bus.sprcoll = 1'b1;
        bus.sprcoll_ad = 10'h209;
        #1;
        check("t4_full_pop_drop", 32'(bus.drop), 0);
        @(negedge clk);
        bus.sprcoll = 1'b0;
        repeat (40) @(posedge clk);
        for (int i = 0; i < 10; i++) rd_chk($sformatf("t4_rd_%0d", i), 1'b0, 10'h200 + 10'(i), i == 8 ? 8'hFE : 8'hFF);
`ifdef SEGASYS1_SPRCOLL_STAT_EN
        check("t4_fifo_hwm", 32'(bus.fifo_hwm), 8);
        check("t4_drop_cnt", 32'(bus.drop_cnt), 1);
        wr_op(1'b1, 10'h000);
        check("t4_drop_cnt_clr", 32'(bus.drop_cnt), 0);
`endif
        // Events on consecutive cycles while the CPU streams back-to-back reads: nothing lost.
        fork
            begin
                logic [7:0] sd;
                int sl;
                for (int k = 0; k < 12; k++) begin
                    cpu_op(1'b0, 1'b0, 10'h100 + 10'(k), sd, sl);
                    check($sformatf("t4s_rd_%0d", k), 32'(sd), 32'h0FE);
                end
            end
            begin
                repeat (6) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    bus.sprcoll = 1'b1;
                    bus.sprcoll_ad = 10'h240 + 10'(i);
                    #1;
                    check($sformatf("t4s_drop_%0d", i), 32'(bus.drop), 0);
                    @(negedge clk);
                end
                bus.sprcoll = 1'b0;
            end
        join
        repeat (40) @(posedge clk);
        for (int i = 0; i < 9; i++) rd_chk($sformatf("t4s_evt_%0d", i), 1'b0, 10'h240 + 10'(i), 8'hFF);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
